mc_ctrl: RTL

Multicycle control unit for the MIPS core. It replaces the single-cycle combinational opcode decoder with a Moore state machine that sequences fetch, decode, execute, memory and writeback over several cycles on a shared ALU and a unified memory. It adds a memory-ready handshake with a watchdog, and a sticky trap on illegal opcodes. It sits between the instruction register (IR) and the multicycle datapath muxes/enables.

---
 rtl/mc_ctrl_if.sv | 42 ++++
 rtl/mc_ctrl.sv | 211 +++++++++++++++++++++
 2 files changed

// File: rtl/mc_ctrl_if.sv
// mc_ctrl_if: bundles the instruction fields, memory/ALU status and all
// datapath control strobes exchanged between the multicycle controller and
// the MIPS datapath.
//   master : the controller (drives control strobes, reads IR fields/status)
//   slave  : the datapath (drives IR fields/status, reads control strobes)
interface mc_ctrl_if;
  logic [5:0] opcode;
  logic [5:0] funct;
  logic       mem_ready;
  logic       zero;
  logic       pcwrite;
  logic       iord;
  logic       irwrite;
  logic       memread;
  logic       memwrite;
  logic       memtoreg;
  logic       regwrite;
  logic       regdst;
  logic       link;
  logic       signext;
  logic       alusrca;
  logic [1:0] alusrcb;
  logic [1:0] aluop;
  logic [1:0] pcsrc;
  logic       trap;
  logic [1:0] trap_cause;
  logic [3:0] state;

  modport master (
    input  opcode, funct, mem_ready, zero,
    output pcwrite, iord, irwrite, memread, memwrite, memtoreg, regwrite,
           regdst, link, signext, alusrca, alusrcb, aluop, pcsrc,
           trap, trap_cause, state
  );

  modport slave (
    output opcode, funct, mem_ready, zero,
    input  pcwrite, iord, irwrite, memread, memwrite, memtoreg, regwrite,
           regdst, link, signext, alusrca, alusrcb, aluop, pcsrc,
           trap, trap_cause, state
  );
endinterface

// File: rtl/mc_ctrl.sv
// mc_ctrl: multicycle MIPS control unit. A Moore FSM sequences fetch,
// decode, execute, memory and writeback on a shared ALU and unified memory.
// Memory states wait on mem_ready under a watchdog; illegal opcodes and
// watchdog expiry park the FSM in a sticky TRAP state until reset.
// Ports:
//   clk   - rising-edge clock
//   rst_n - asynchronous active-low reset
//   bus   - mc_ctrl_if.master: opcode/funct/mem_ready/zero in, datapath
//           control strobes, trap/trap_cause and debug state out
// Parameters:
//   WAIT_EN     - 1 honours mem_ready; 0 treats it as 1 and disables watchdog
//   MEM_TIMEOUT - wait cycles allowed in a memory state before trapping (0 = off)
module mc_ctrl #(
  parameter bit WAIT_EN     = 1'b1,
  parameter int MEM_TIMEOUT = 255
) (
  input logic       clk,
  input logic       rst_n,
  mc_ctrl_if.master bus
);

  localparam int CNT_W = (MEM_TIMEOUT > 0) ? $clog2(MEM_TIMEOUT + 1) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(MEM_TIMEOUT);
  localparam bit WDOG_EN = WAIT_EN && (MEM_TIMEOUT != 0);

  typedef enum logic [3:0] {
    S_RESET  = 4'd0,  S_FETCH  = 4'd1,  S_DECODE = 4'd2,  S_MEMADR = 4'd3,
    S_MEMRD  = 4'd4,  S_MEMWB  = 4'd5,  S_MEMWR  = 4'd6,  S_EXEC   = 4'd7,
    S_ALUWB  = 4'd8,  S_IEXEC  = 4'd9,  S_IWB    = 4'd10, S_BRANCH = 4'd11,
    S_JUMP   = 4'd12, S_JR     = 4'd13, S_TRAP   = 4'd14
  } state_t;

  state_t           state_q, state_d;
  logic [5:0]       op_q, op_d;
  logic [5:0]       fn_q, fn_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             trap_q, trap_d;
  logic [1:0]       cause_q, cause_d;

  logic ready;
  logic waiting;
  logic timeout;

  // With the handshake disabled every memory access completes immediately.
  assign ready   = WAIT_EN ? bus.mem_ready : 1'b1;
  assign waiting = (state_q == S_FETCH) || (state_q == S_MEMRD) || (state_q == S_MEMWR);
  // A ready in the expiry cycle wins, so only a stalled access can time out.
  assign timeout = WDOG_EN && waiting && !ready && (cnt_q == CNT_MAX);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_RESET;
      op_q    <= '0;
      fn_q    <= '0;
      cnt_q   <= '0;
      trap_q  <= 1'b0;
      cause_q <= 2'b00;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      fn_q    <= fn_d;
      cnt_q   <= cnt_d;
      trap_q  <= trap_d;
      cause_q <= cause_d;
    end
  end

  // Next-state logic. Decode looks at the live IR only in DECODE; every later
  // state works from the latched op_q so IR reloads cannot disturb it.
  always_comb begin
    state_d = state_q;
    op_d    = op_q;
    fn_d    = fn_q;
    trap_d  = trap_q;
    cause_d = cause_q;
    cnt_d   = cnt_q;

    unique case (state_q)
      S_RESET:  state_d = S_FETCH;
      S_FETCH:  if (ready) state_d = S_DECODE;
      S_DECODE: begin
        op_d = bus.opcode;
        fn_d = bus.funct;
        casez (bus.opcode)
          6'h23, 6'h2b: state_d = S_MEMADR;
          6'h00:        state_d = (bus.funct == 6'h08) ? S_JR : S_EXEC;
          6'h04, 6'h05: state_d = S_BRANCH;
          6'h02, 6'h03: state_d = S_JUMP;
          6'b001???:    state_d = S_IEXEC;
          default: begin
            state_d = S_TRAP;
            cause_d = 2'b01;
          end
        endcase
      end
      S_MEMADR: state_d = (op_q == 6'h23) ? S_MEMRD : S_MEMWR;
      S_MEMRD:  if (ready) state_d = S_MEMWB;
      S_MEMWR:  if (ready) state_d = S_FETCH;
      S_EXEC:   state_d = S_ALUWB;
      S_IEXEC:  state_d = S_IWB;
      S_MEMWB, S_ALUWB, S_IWB, S_BRANCH, S_JUMP, S_JR: state_d = S_FETCH;
      S_TRAP:   state_d = S_TRAP;
      default:  state_d = S_RESET;
    endcase

    if (timeout) begin
      state_d = S_TRAP;
      cause_d = 2'b10;
    end

    if (state_d == S_TRAP) trap_d = 1'b1;

    // Watchdog restarts on every state entry and only counts stalled cycles.
    if (state_d != state_q) begin
      cnt_d = '0;
    end else if (WDOG_EN && waiting && !ready) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  // Moore outputs; fetch/branch enables also depend on mem_ready/zero.
  always_comb begin
    bus.pcwrite  = 1'b0;
    bus.iord     = 1'b0;
    bus.irwrite  = 1'b0;
    bus.memread  = 1'b0;
    bus.memwrite = 1'b0;
    bus.memtoreg = 1'b0;
    bus.regwrite = 1'b0;
    bus.regdst   = 1'b0;
    bus.link     = 1'b0;
    bus.signext  = 1'b0;
    bus.alusrca  = 1'b0;
    bus.alusrcb  = 2'b00;
    bus.aluop    = 2'b00;
    bus.pcsrc    = 2'b00;

    case (state_q)
      S_FETCH: begin
        bus.memread = 1'b1;
        bus.alusrcb = 2'b01;
        bus.irwrite = ready;
        bus.pcwrite = ready;
      end
      S_DECODE: begin
        bus.alusrcb = 2'b11;
        bus.signext = 1'b1;
      end
      S_MEMADR: begin
        bus.alusrca = 1'b1;
        bus.alusrcb = 2'b10;
        bus.signext = 1'b1;
      end
      S_MEMRD: begin
        bus.memread = 1'b1;
        bus.iord    = 1'b1;
      end
      S_MEMWB: begin
        bus.regwrite = 1'b1;
        bus.memtoreg = 1'b1;
      end
      S_MEMWR: begin
        bus.memwrite = 1'b1;
        bus.iord     = 1'b1;
      end
      S_EXEC: begin
        bus.alusrca = 1'b1;
        bus.aluop   = 2'b10;
      end
      S_ALUWB: begin
        bus.regwrite = 1'b1;
        bus.regdst   = 1'b1;
      end
      // Logical immediates (andi/ori/xori, op bit 2 set) zero-extend.
      S_IEXEC: begin
        bus.alusrca = 1'b1;
        bus.alusrcb = 2'b10;
        bus.aluop   = 2'b11;
        bus.signext = ~op_q[2];
      end
      S_IWB: begin
        bus.regwrite = 1'b1;
        bus.signext  = ~op_q[2];
      end
      // bne has op bit 0 set, which inverts the taken condition.
      S_BRANCH: begin
        bus.alusrca = 1'b1;
        bus.aluop   = 2'b01;
        bus.pcsrc   = 2'b01;
        bus.pcwrite = bus.zero ^ op_q[0];
      end
      // jal writes the PC+4 captured during FETCH into r31.
      S_JUMP: begin
        bus.pcsrc    = 2'b10;
        bus.pcwrite  = 1'b1;
        bus.link     = op_q[0];
        bus.regwrite = op_q[0];
      end
      S_JR: begin
        bus.pcsrc   = 2'b11;
        bus.pcwrite = 1'b1;
      end
      default: ;
    endcase
  end

  assign bus.trap       = trap_q;
  assign bus.trap_cause = cause_q;
  assign bus.state      = state_q;

endmodule
